// File: rtl/bit_converter_fifo.sv
// Activation bit-place converter: buffers 8-bit values, then emits the index of
// every set bit (LSB first) into a first-word-fall-through bit-place FIFO.
module bit_converter_fifo #(
    parameter int unsigned VAL_DEPTH = 16,
    parameter int unsigned POS_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [7:0] ActValuesFIFOWriteDataIn,
    input  logic       ActValuesFIFOWriteEnable,
    input  logic       ActBitPlacesFIFOReadEnable,
    output logic       ActValuesFIFOWriteReady,
    output logic       ActBitPlacesFIFOReadReady,
    output logic [2:0] ActBitPlacesFIFOReadDataOut
);

    localparam int unsigned VAL_AW = $clog2(VAL_DEPTH);
    localparam int unsigned POS_AW = $clog2(POS_DEPTH);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    // ---------------- value FIFO ----------------
    logic [DATA_W-1:0] val_mem [VAL_DEPTH];
    logic [VAL_AW:0]   val_wr_q, val_rd_q;
    logic              val_empty, val_full, val_push, val_pop;
    logic [DATA_W-1:0] val_head;

    // Extra MSB on each pointer separates full from empty when low bits match.
    assign val_empty = (val_wr_q == val_rd_q);
    assign val_full  = (val_wr_q[VAL_AW] != val_rd_q[VAL_AW]) &&
                       (val_wr_q[VAL_AW-1:0] == val_rd_q[VAL_AW-1:0]);
    assign val_push  = ActValuesFIFOWriteEnable && !val_full;
    assign val_head  = val_mem[val_rd_q[VAL_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (val_push) begin
            val_mem[val_wr_q[VAL_AW-1:0]] <= ActValuesFIFOWriteDataIn;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            val_wr_q <= '0;
            val_rd_q <= '0;
        end else begin
            if (val_push) val_wr_q <= val_wr_q + (VAL_AW+1)'(1);
            if (val_pop)  val_rd_q <= val_rd_q + (VAL_AW+1)'(1);
        end
    end

    // ---------------- bit-place FIFO ----------------
    logic [IDX_W-1:0] pos_mem [POS_DEPTH];
    logic [POS_AW:0]  pos_wr_q, pos_rd_q;
    logic             pos_empty, pos_full, pos_push, pos_pop;
    logic [IDX_W-1:0] pos_din;

    assign pos_empty = (pos_wr_q == pos_rd_q);
    assign pos_full  = (pos_wr_q[POS_AW] != pos_rd_q[POS_AW]) &&
                       (pos_wr_q[POS_AW-1:0] == pos_rd_q[POS_AW-1:0]);
    assign pos_pop   = ActBitPlacesFIFOReadEnable && !pos_empty;

    always_ff @(posedge CLK) begin
        if (pos_push) begin
            pos_mem[pos_wr_q[POS_AW-1:0]] <= pos_din;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pos_wr_q <= '0;
            pos_rd_q <= '0;
        end else begin
            if (pos_push) pos_wr_q <= pos_wr_q + (POS_AW+1)'(1);
            if (pos_pop)  pos_rd_q <= pos_rd_q + (POS_AW+1)'(1);
        end
    end

    // ---------------- converter ----------------
    state_e            state_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] rem_cleared;

    assign val_pop     = (state_q == IDLE) && !val_empty;
    assign pos_push    = (state_q == CONVERT) && !pos_full;
    assign rem_cleared = rem_q & (rem_q - DATA_W'(1));

    // Lowest set bit wins: scan from MSB down so the last hit is the lowest.
    always_comb begin
        pos_din = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (rem_q[i]) pos_din = IDX_W'(i);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (val_pop && (val_head != '0)) begin
                        rem_q   <= val_head;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (pos_push) begin
                        rem_q <= rem_cleared;
                        if (rem_cleared == '0) state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign ActValuesFIFOWriteReady     = !val_full;
    assign ActBitPlacesFIFOReadReady   = !pos_empty;
    assign ActBitPlacesFIFOReadDataOut = pos_empty ? IDX_W'(0) : pos_mem[pos_rd_q[POS_AW-1:0]];

endmodule

// File: tb/tb_bit_converter_fifo.sv
// Directed bench for bit_converter_fifo: timing, ordering, backpressure and reset.
module tb_bit_converter_fifo;

    logic       CLK;
    logic       RSTN;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic       wready;
    logic       rready;
    logic [2:0] rdata;

    int vectors;
    int errors;
    int got;

    bit_converter_fifo #(
        .VAL_DEPTH(16),
        .POS_DEPTH(16)
    ) dut (
        .CLK                        (CLK),
        .RSTN                       (RSTN),
        .ActValuesFIFOWriteDataIn   (wdata),
        .ActValuesFIFOWriteEnable   (we),
        .ActBitPlacesFIFOReadEnable (re),
        .ActValuesFIFOWriteReady    (wready),
        .ActBitPlacesFIFOReadReady  (rready),
        .ActBitPlacesFIFOReadDataOut(rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RSTN    = 1'b0;
        wdata   = 8'h00;
        we      = 1'b0;
        re      = 1'b0;

        // Reset values while held in reset
        #12;
        chk("rst_wready", 8'(wready), 8'd1);
        chk("rst_rready", 8'(rready), 8'd0);
        chk("rst_rdata",  8'(rdata),  8'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        step();

        // ReadEnable pulsed while empty: nothing changes
        re = 1'b1;
        step();
        chk("empty_re_rready", 8'(rready), 8'd0);
        chk("empty_re_rdata",  8'(rdata),  8'd0);
        re = 1'b0;
        step();
        chk("empty_re_wready", 8'(wready), 8'd1);

        // 0x11 with ReadEnable held: places 0 then 4
        re = 1'b1;
        wdata = 8'h11;
        we = 1'b1;
        step();                       // edge t: write
        we = 1'b0;
        chk("x11_t_rready", 8'(rready), 8'd0);
        step();                       // t+1: pop
        chk("x11_t1_rready", 8'(rready), 8'd0);
        step();                       // t+2: push 0
        chk("x11_t2_rready", 8'(rready), 8'd1);
        chk("x11_t2_rdata",  8'(rdata),  8'd0);
        step();                       // t+3: pop 0, push 4
        chk("x11_t3_rready", 8'(rready), 8'd1);
        chk("x11_t3_rdata",  8'(rdata),  8'd4);
        step();                       // t+4: pop 4
        chk("x11_t4_rready", 8'(rready), 8'd0);
        chk("x11_t4_rdata",  8'(rdata),  8'd0);

        // 0x00 then 0x80: zero is discarded, only place 7 appears
        wdata = 8'h00;
        we = 1'b1;
        step();
        wdata = 8'h80;
        step();
        we = 1'b0;
        chk("zero_t1_rready", 8'(rready), 8'd0);
        step();
        chk("zero_t2_rready", 8'(rready), 8'd0);
        step();
        chk("x80_rready", 8'(rready), 8'd1);
        chk("x80_rdata",  8'(rdata),  8'd7);
        step();
        chk("x80_done_rready", 8'(rready), 8'd0);
        step();
        chk("x80_quiet_rready", 8'(rready), 8'd0);

        // 0xFF: eight places in consecutive cycles
        wdata = 8'hFF;
        we = 1'b1;
        step();
        we = 1'b0;
        step();
        chk("xff_pop_rready", 8'(rready), 8'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("xff_rready", 8'(rready), 8'd1);
            chk("xff_place",  8'(rdata),  8'(k));
        end
        step();
        chk("xff_done_rready", 8'(rready), 8'd0);

        // Backpressure: 100 writes of 0x11 with no reads; 25 get accepted
        re = 1'b0;
        wdata = 8'h11;
        we = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (e == 24) chk("bp_full_e24",   8'(wready), 8'd0);
            if (e == 26) chk("bp_freed_e26",  8'(wready), 8'd1);
            if (e == 27) chk("bp_refull_e27", 8'(wready), 8'd0);
        end
        we = 1'b0;
        chk("bp_end_wready", 8'(wready), 8'd0);
        chk("bp_end_rready", 8'(rready), 8'd1);
        re = 1'b1;
        got = 0;
        for (int c = 0; c < 400 && got < 50; c++) begin
            if (rready) begin
                chk("bp_drain_place", 8'(rdata), (got % 2 == 0) ? 8'd0 : 8'd4);
                got++;
            end
            step();
        end
        chk("bp_drain_count", 8'(got), 8'd50);
        chk("bp_drain_rready", 8'(rready), 8'd0);
        chk("bp_drain_wready", 8'(wready), 8'd1);

        // Asynchronous reset mid-stream discards everything
        re = 1'b0;
        we = 1'b1;
        wdata = 8'h11;
        step();
        wdata = 8'hFF;
        step();
        wdata = 8'h80;
        step();
        we = 1'b0;
        step();
        chk("mid_pre_rready", 8'(rready), 8'd1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_wready", 8'(wready), 8'd1);
        chk("mid_rst_rready", 8'(rready), 8'd0);
        chk("mid_rst_rdata",  8'(rdata),  8'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        re = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_rready", 8'(rready), 8'd0);
            chk("post_rst_rdata",  8'(rdata),  8'd0);
        end
        chk("post_rst_wready", 8'(wready), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
